// File: rtl/io_dev_arbiter.sv
// Shares the I/O unit's character-wide device port between peripherals: round-robin
// arbitration on the input side, acknowledged broadcast on the output side, per-side watchdogs.
module io_dev_arbiter #(
    parameter int N_IN       = 2,
    parameter int N_OUT      = 2,
    parameter int TMO_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 resetn,
    // I/O unit, input direction
    input  logic                 input_rdy_from_io,
    output logic                 input_val_to_io,
    output logic [4:0]           input_data_to_io,
    // I/O unit, output direction
    input  logic                 output_rdy_from_io,
    input  logic [4:0]           output_data_from_io,
    output logic                 output_ack_to_io,
    // input devices
    input  logic [N_IN-1:0]      in_req_from_dev,
    output logic [N_IN-1:0]      in_rdy_to_dev,
    input  logic [N_IN-1:0]      in_val_from_dev,
    input  logic [5*N_IN-1:0]    in_data_from_dev,
    // output devices
    output logic [N_OUT-1:0]     out_rdy_to_dev,
    input  logic [N_OUT-1:0]     out_ack_from_dev,
    output logic [4:0]           out_data_to_dev,
    // operator panel
    input  logic [N_IN-1:0]      in_en_from_pnl,
    input  logic [N_OUT-1:0]     out_en_from_pnl,
    input  logic                 tmo_clr_from_pnl,
    output logic [N_IN-1:0]      in_grant_to_pnl,
    output logic                 in_tmo_to_pnl,
    output logic                 out_tmo_to_pnl
);

    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CW = $clog2(TMO_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

    // Handshake: a device character moves when in_val is seen while the device is
    // granted; the device holds val until it sees rdy drop, and the I/O unit sees
    // val/data from the granted device combinationally. Output side is a 4-phase
    // rdy/ack loop with the I/O unit and with every targeted device.

    typedef enum logic [1:0] {
        IA_IDLE  = 2'd0,
        IA_GRANT = 2'd1,
        IA_HOLD  = 2'd2
    } ia_state_t;

    typedef enum logic [1:0] {
        OA_IDLE = 2'd0,
        OA_WAIT = 2'd1,
        OA_ACK  = 2'd2
    } oa_state_t;

    // ------------------------------------------------------------------ input side
    ia_state_t        ia_state_q, ia_state_d;
    logic [N_IN-1:0]  grant_q, grant_d;
    logic [PW-1:0]    gidx_q, gidx_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    in_cnt_q, in_cnt_d;
    logic             in_tmo_q, in_tmo_d;

    logic [N_IN-1:0]  eligible;
    logic [PW-1:0]    sel_idx;
    logic [PW-1:0]    idx_hi, idx_lo;
    logic             found_hi, found_lo;
    logic [4:0]       dev_data [N_IN];
    logic             g_val;
    logic [4:0]       g_data;
    logic [PW-1:0]    ptr_after_g;
    logic             in_busy;
    logic             in_tmo_set;

    assign eligible = in_req_from_dev & in_en_from_pnl;

    // First eligible device at or above the pointer, else the lowest one (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (eligible[i] && !found_hi && (PW'(i) >= ptr_q)) begin
                found_hi = 1'b1;
                idx_hi   = PW'(i);
            end
            if (eligible[i] && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = PW'(i);
            end
        end
        sel_idx = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            dev_data[i] = in_data_from_dev[i*5 +: 5];
        end
    end

    assign g_val       = in_val_from_dev[gidx_q];
    assign g_data      = dev_data[gidx_q];
    assign ptr_after_g = (gidx_q == PW'(N_IN - 1)) ? '0 : gidx_q + PW'(1);
    assign in_busy     = (ia_state_q == IA_GRANT) || (ia_state_q == IA_HOLD);

    always_comb begin
        ia_state_d = ia_state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        in_cnt_d   = in_cnt_q + CW'(1);
        in_tmo_set = 1'b0;
        case (ia_state_q)
            IA_IDLE: begin
                in_cnt_d = '0;
                if (input_rdy_from_io && (|eligible)) begin
                    ia_state_d = IA_GRANT;
                    gidx_d     = sel_idx;
                    grant_d    = N_IN'(1) << sel_idx;
                end
            end
            IA_GRANT: begin
                if (g_val) begin
                    ia_state_d = IA_HOLD;
                    in_cnt_d   = '0;
                end else if (!input_rdy_from_io) begin
                    ia_state_d = IA_IDLE;
                    grant_d    = '0;
                    in_cnt_d   = '0;
                end else if (in_cnt_q == CNT_LAST) begin
                    ia_state_d = IA_IDLE;
                    grant_d    = '0;
                    ptr_d      = ptr_after_g;
                    in_cnt_d   = '0;
                    in_tmo_set = 1'b1;
                end
            end
            IA_HOLD: begin
                // Pointer moves past g on completion and on timeout alike.
                if (!g_val || (in_cnt_q == CNT_LAST)) begin
                    ia_state_d = IA_IDLE;
                    grant_d    = '0;
                    ptr_d      = ptr_after_g;
                    in_cnt_d   = '0;
                    in_tmo_set = g_val;
                end
            end
            default: begin
                ia_state_d = IA_IDLE;
                grant_d    = '0;
                in_cnt_d   = '0;
            end
        endcase
        in_tmo_d = in_tmo_set | (in_tmo_q & ~tmo_clr_from_pnl);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ia_state_q <= IA_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            in_cnt_q   <= '0;
            in_tmo_q   <= 1'b0;
        end else begin
            ia_state_q <= ia_state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            in_cnt_q   <= in_cnt_d;
            in_tmo_q   <= in_tmo_d;
        end
    end

    assign in_rdy_to_dev    = ((ia_state_q == IA_GRANT) && input_rdy_from_io) ? grant_q : '0;
    assign input_val_to_io  = in_busy & g_val;
    assign input_data_to_io = in_busy ? g_data : 5'd0;
    assign in_grant_to_pnl  = grant_q;
    assign in_tmo_to_pnl    = in_tmo_q;

    // ----------------------------------------------------------------- output side
    oa_state_t        oa_state_q, oa_state_d;
    logic [N_OUT-1:0] tgt_q, tgt_d;
    logic [N_OUT-1:0] acked_q, acked_d;
    logic [4:0]       odata_q, odata_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic             out_tmo_q, out_tmo_d;
    logic             out_tmo_set;
    logic [N_OUT-1:0] ack_hit;

    assign ack_hit = out_ack_from_dev & tgt_q;

    always_comb begin
        oa_state_d  = oa_state_q;
        tgt_d       = tgt_q;
        acked_d     = acked_q;
        odata_d     = odata_q;
        out_cnt_d   = out_cnt_q + CW'(1);
        out_tmo_set = 1'b0;
        case (oa_state_q)
            OA_IDLE: begin
                out_cnt_d = '0;
                if (output_rdy_from_io) begin
                    odata_d    = output_data_from_io;
                    tgt_d      = out_en_from_pnl;
                    acked_d    = '0;
                    // No enabled target: the character is simply dropped.
                    oa_state_d = (out_en_from_pnl == '0) ? OA_ACK : OA_WAIT;
                end
            end
            OA_WAIT: begin
                acked_d = acked_q | ack_hit;
                if ((acked_q | ack_hit) == tgt_q) begin
                    oa_state_d = OA_ACK;
                    out_cnt_d  = '0;
                end else if (out_cnt_q == CNT_LAST) begin
                    oa_state_d  = OA_ACK;
                    acked_d     = tgt_q;
                    out_cnt_d   = '0;
                    out_tmo_set = 1'b1;
                end
            end
            OA_ACK: begin
                if (!output_rdy_from_io && !(|ack_hit)) begin
                    oa_state_d = OA_IDLE;
                    out_cnt_d  = '0;
                end else if (out_cnt_q == CNT_LAST) begin
                    oa_state_d  = OA_IDLE;
                    out_cnt_d   = '0;
                    out_tmo_set = 1'b1;
                end
            end
            default: begin
                oa_state_d = OA_IDLE;
                out_cnt_d  = '0;
            end
        endcase
        out_tmo_d = out_tmo_set | (out_tmo_q & ~tmo_clr_from_pnl);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            oa_state_q <= OA_IDLE;
            tgt_q      <= '0;
            acked_q    <= '0;
            odata_q    <= '0;
            out_cnt_q  <= '0;
            out_tmo_q  <= 1'b0;
        end else begin
            oa_state_q <= oa_state_d;
            tgt_q      <= tgt_d;
            acked_q    <= acked_d;
            odata_q    <= odata_d;
            out_cnt_q  <= out_cnt_d;
            out_tmo_q  <= out_tmo_d;
        end
    end

    assign out_rdy_to_dev   = (oa_state_q == OA_WAIT) ? (tgt_q & ~acked_q) : '0;
    assign output_ack_to_io = (oa_state_q == OA_ACK);
    assign out_data_to_dev  = odata_q;
    assign out_tmo_to_pnl   = out_tmo_q;

endmodule

// File: tb/tb_io_dev_arbiter.sv
// Bench for io_dev_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_io_dev_arbiter;

  localparam int N_IN  = 2;
  localparam int N_OUT = 2;
  localparam int TMO   = 8;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               input_rdy_from_io = 1'b0;
  logic               input_val_to_io;
  logic [4:0]         input_data_to_io;
  logic               output_rdy_from_io = 1'b0;
  logic [4:0]         output_data_from_io = '0;
  logic               output_ack_to_io;
  logic [N_IN-1:0]    in_req_from_dev = '0;
  logic [N_IN-1:0]    in_rdy_to_dev;
  logic [N_IN-1:0]    in_val_from_dev = '0;
  logic [5*N_IN-1:0]  in_data_from_dev = '0;
  logic [N_OUT-1:0]   out_rdy_to_dev;
  logic [N_OUT-1:0]   out_ack_from_dev = '0;
  logic [4:0]         out_data_to_dev;
  logic [N_IN-1:0]    in_en_from_pnl = '0;
  logic [N_OUT-1:0]   out_en_from_pnl = '0;
  logic               tmo_clr_from_pnl = 1'b0;
  logic [N_IN-1:0]    in_grant_to_pnl;
  logic               in_tmo_to_pnl;
  logic               out_tmo_to_pnl;

  int checks = 0;
  int failures = 0;

  io_dev_arbiter #(.N_IN(N_IN), .N_OUT(N_OUT), .TMO_CYCLES(TMO)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .input_rdy_from_io   (input_rdy_from_io),
    .input_val_to_io     (input_val_to_io),
    .input_data_to_io    (input_data_to_io),
    .output_rdy_from_io  (output_rdy_from_io),
    .output_data_from_io (output_data_from_io),
    .output_ack_to_io    (output_ack_to_io),
    .in_req_from_dev     (in_req_from_dev),
    .in_rdy_to_dev       (in_rdy_to_dev),
    .in_val_from_dev     (in_val_from_dev),
    .in_data_from_dev    (in_data_from_dev),
    .out_rdy_to_dev      (out_rdy_to_dev),
    .out_ack_from_dev    (out_ack_from_dev),
    .out_data_to_dev     (out_data_to_dev),
    .in_en_from_pnl      (in_en_from_pnl),
    .out_en_from_pnl     (out_en_from_pnl),
    .tmo_clr_from_pnl    (tmo_clr_from_pnl),
    .in_grant_to_pnl     (in_grant_to_pnl),
    .in_tmo_to_pnl       (in_tmo_to_pnl),
    .out_tmo_to_pnl      (out_tmo_to_pnl)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {12'd0, input_val_to_io, input_data_to_io, output_ack_to_io, in_rdy_to_dev,
            out_rdy_to_dev, out_data_to_dev, in_grant_to_pnl, in_tmo_to_pnl, out_tmo_to_pnl};
  endfunction

  // ---------------------------------------------------------------- model
  // Input side: phase 0 = nobody holds the port, 1 = device offered the port,
  // 2 = device's character is on the bus until it drops val.
  int             m_in_phase = 0, m_holder = 0, m_rr = 0, m_in_age = 0;
  bit             m_in_tmo = 0;
  // Output side: phase 0 = free, 1 = collecting device acks, 2 = acking the I/O unit.
  int             m_out_phase = 0, m_out_age = 0;
  logic [4:0]     m_char = '0;
  logic [N_OUT-1:0] m_targets = '0, m_waiting = '0;
  bit             m_out_tmo = 0;

  task automatic model_reset();
    m_in_phase = 0; m_holder = 0; m_rr = 0; m_in_age = 0; m_in_tmo = 0;
    m_out_phase = 0; m_out_age = 0; m_char = '0; m_targets = '0; m_waiting = '0; m_out_tmo = 0;
  endtask

  task automatic model_step();
    bit found;
    int idx;
    bit itmo, otmo;
    itmo = m_in_tmo && !tmo_clr_from_pnl;
    if (m_in_phase == 0) begin
      if (input_rdy_from_io) begin
        found = 0;
        for (int k = 0; k < N_IN; k++) begin
          idx = (m_rr + k) % N_IN;
          if (!found && in_req_from_dev[idx] && in_en_from_pnl[idx]) begin
            found = 1;
            m_holder = idx;
          end
        end
        if (found) begin m_in_phase = 1; m_in_age = 0; end
      end
    end else if (m_in_phase == 1) begin
      if (in_val_from_dev[m_holder]) begin m_in_phase = 2; m_in_age = 0; end
      else if (!input_rdy_from_io) m_in_phase = 0;
      else if (m_in_age + 1 == TMO) begin
        m_in_phase = 0; itmo = 1; m_rr = (m_holder + 1) % N_IN;
      end else m_in_age++;
    end else begin
      if (!in_val_from_dev[m_holder]) begin m_in_phase = 0; m_rr = (m_holder + 1) % N_IN; end
      else if (m_in_age + 1 == TMO) begin
        m_in_phase = 0; itmo = 1; m_rr = (m_holder + 1) % N_IN;
      end else m_in_age++;
    end
    m_in_tmo = itmo;

    otmo = m_out_tmo && !tmo_clr_from_pnl;
    if (m_out_phase == 0) begin
      if (output_rdy_from_io) begin
        m_char = output_data_from_io;
        m_targets = out_en_from_pnl;
        m_waiting = out_en_from_pnl;
        m_out_age = 0;
        m_out_phase = (out_en_from_pnl == '0) ? 2 : 1;
      end
    end else if (m_out_phase == 1) begin
      m_waiting = m_waiting & ~out_ack_from_dev;
      if (m_waiting == '0) begin m_out_phase = 2; m_out_age = 0; end
      else if (m_out_age + 1 == TMO) begin m_out_phase = 2; m_out_age = 0; otmo = 1; end
      else m_out_age++;
    end else begin
      if (!output_rdy_from_io && ((out_ack_from_dev & m_targets) == '0)) m_out_phase = 0;
      else if (m_out_age + 1 == TMO) begin m_out_phase = 0; otmo = 1; end
      else m_out_age++;
    end
    m_out_tmo = otmo;
  endtask

  // Model advances on the same edge as the DUT, with the inputs held over that edge.
  always @(posedge clk) begin
    if (resetn) model_step();
  end

  // ---------------------------------------------------------------- compare process
  always @(negedge clk) begin
    logic [N_IN-1:0]  e_grant, e_irdy;
    logic [N_OUT-1:0] e_ordy;
    logic             e_val;
    logic [4:0]       e_data;
    if (!resetn) model_reset();
    e_grant = '0; e_irdy = '0; e_val = 1'b0; e_data = '0;
    if (m_in_phase != 0) begin
      e_grant[m_holder] = 1'b1;
      e_val  = in_val_from_dev[m_holder];
      e_data = in_data_from_dev[m_holder*5 +: 5];
      if (m_in_phase == 1 && input_rdy_from_io) e_irdy[m_holder] = 1'b1;
    end
    e_ordy = (m_out_phase == 1) ? m_waiting : '0;
    chk("cmp_in_grant", in_grant_to_pnl, e_grant);
    chk("cmp_in_rdy", in_rdy_to_dev, e_irdy);
    chk("cmp_in_val", input_val_to_io, e_val);
    chk("cmp_in_data", input_data_to_io, e_data);
    chk("cmp_in_tmo", in_tmo_to_pnl, m_in_tmo);
    chk("cmp_out_rdy", out_rdy_to_dev, e_ordy);
    chk("cmp_out_ack", output_ack_to_io, (m_out_phase == 2));
    chk("cmp_out_data", out_data_to_dev, m_char);
    chk("cmp_out_tmo", out_tmo_to_pnl, m_out_tmo);
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int p_io, p_val, p_req, p_ack, p_ordy;

    // reset
    repeat (2) @(posedge clk);
    #3;
    chk("reset_outputs", all_outs(), 32'd0);
    resetn = 1'b1;
    tick();

    // round robin with both devices requesting
    input_rdy_from_io = 1'b1; in_en_from_pnl = 2'b11; in_req_from_dev = 2'b11;
    in_data_from_dev = {5'h06, 5'h13};
    tick();
    chk("rr_grant0", in_grant_to_pnl, 2'b01);
    chk("rr_rdy0", in_rdy_to_dev, 2'b01);
    in_val_from_dev = 2'b01; #1;
    chk("rr_val0", input_val_to_io, 1'b1);
    chk("rr_data0", input_data_to_io, 5'h13);
    tick(); in_val_from_dev = 2'b00;
    tick(); tick();
    chk("rr_grant1", in_grant_to_pnl, 2'b10);
    in_val_from_dev = 2'b10; #1;
    chk("rr_data1", input_data_to_io, 5'h06);
    tick(); in_val_from_dev = 2'b00;
    tick(); tick();
    chk("rr_grant2", in_grant_to_pnl, 2'b01);
    input_rdy_from_io = 1'b0; in_req_from_dev = 2'b00;
    tick();
    chk("rr_abandon", in_grant_to_pnl, 2'b00);

    // disabled requester is ignored
    in_en_from_pnl = 2'b10; in_req_from_dev = 2'b01; input_rdy_from_io = 1'b1;
    tick(); tick();
    chk("en_no_grant", in_grant_to_pnl, 2'b00);
    chk("en_no_rdy", in_rdy_to_dev, 2'b00);
    in_req_from_dev = 2'b11;
    tick();
    chk("en_grant1", in_grant_to_pnl, 2'b10);
    input_rdy_from_io = 1'b0; in_req_from_dev = 2'b00; in_en_from_pnl = 2'b11;
    tick();

    // broadcast with staggered acks
    output_rdy_from_io = 1'b1; output_data_from_io = 5'h1A; out_en_from_pnl = 2'b11;
    tick();
    chk("bc_rdy_all", out_rdy_to_dev, 2'b11);
    chk("bc_data", out_data_to_dev, 5'h1A);
    tick(); tick();
    out_ack_from_dev = 2'b10; #1;
    chk("bc_no_ack_c3", output_ack_to_io, 1'b0);
    tick(); out_ack_from_dev = 2'b00;
    chk("bc_rdy_dev0", out_rdy_to_dev, 2'b01);
    tick(); tick(); tick();
    out_ack_from_dev = 2'b01; #1;
    chk("bc_no_ack_c7", output_ack_to_io, 1'b0);
    tick();
    chk("bc_ack", output_ack_to_io, 1'b1);
    chk("bc_rdy_off", out_rdy_to_dev, 2'b00);
    out_ack_from_dev = 2'b00; output_rdy_from_io = 1'b0;
    tick();
    chk("bc_ack_drop", output_ack_to_io, 1'b0);

    // no enabled output target
    out_en_from_pnl = 2'b00; output_data_from_io = 5'h06; output_rdy_from_io = 1'b1;
    tick();
    chk("discard_ack", output_ack_to_io, 1'b1);
    chk("discard_no_rdy", out_rdy_to_dev, 2'b00);
    tick();
    chk("discard_ack_hold", output_ack_to_io, 1'b1);
    output_rdy_from_io = 1'b0;
    tick();
    chk("discard_ack_drop", output_ack_to_io, 1'b0);

    // input watchdog on a silent device
    in_en_from_pnl = 2'b11; in_req_from_dev = 2'b11; input_rdy_from_io = 1'b1;
    tick();
    repeat (TMO - 1) tick();
    chk("tmo_not_yet", in_tmo_to_pnl, 1'b0);
    chk("tmo_still_grant", in_grant_to_pnl, 2'b01);
    tick();
    chk("tmo_set", in_tmo_to_pnl, 1'b1);
    chk("tmo_grant_clr", in_grant_to_pnl, 2'b00);
    tick();
    chk("tmo_next_dev", in_grant_to_pnl, 2'b10);
    tmo_clr_from_pnl = 1'b1;
    tick();
    tmo_clr_from_pnl = 1'b0;
    chk("tmo_cleared", in_tmo_to_pnl, 1'b0);
    input_rdy_from_io = 1'b0; in_req_from_dev = 2'b00;
    tick();

    // asynchronous reset in the middle of a broadcast
    out_en_from_pnl = 2'b11; output_data_from_io = 5'h11; output_rdy_from_io = 1'b1;
    tick();
    chk("ar_wait", out_rdy_to_dev, 2'b11);
    #1 resetn = 1'b0;
    #1;
    chk("ar_outputs_zero", all_outs(), 32'd0);
    output_rdy_from_io = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
    output_rdy_from_io = 1'b1; output_data_from_io = 5'h0B;
    tick();
    chk("ar_fresh_data", out_data_to_dev, 5'h0B);
    chk("ar_fresh_rdy", out_rdy_to_dev, 2'b11);
    out_ack_from_dev = 2'b11;
    tick();
    out_ack_from_dev = 2'b00; output_rdy_from_io = 1'b0;
    tick(); tick();

    // randomized traffic, biased differently per segment
    for (int seg = 0; seg < 30; seg++) begin
      p_io = $urandom_range(1, 4); p_val = $urandom_range(0, 4); p_req = $urandom_range(1, 4);
      p_ack = $urandom_range(0, 4); p_ordy = $urandom_range(1, 4);
      repeat (100) begin
        input_rdy_from_io   = ($urandom_range(0, 3) < p_io);
        in_req_from_dev     = {($urandom_range(0, 3) < p_req), ($urandom_range(0, 3) < p_req)};
        in_val_from_dev     = {($urandom_range(0, 3) < p_val), ($urandom_range(0, 3) < p_val)};
        in_data_from_dev    = 10'($urandom);
        in_en_from_pnl      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        output_rdy_from_io  = ($urandom_range(0, 3) < p_ordy);
        output_data_from_io = 5'($urandom);
        out_en_from_pnl     = 2'($urandom_range(0, 3));
        out_ack_from_dev    = {($urandom_range(0, 3) < p_ack), ($urandom_range(0, 3) < p_ack)};
        tmo_clr_from_pnl    = ($urandom_range(0, 15) == 0);
        tick();
      end
    end

    input_rdy_from_io = 1'b0; in_req_from_dev = '0; in_val_from_dev = '0;
    output_rdy_from_io = 1'b0; out_ack_from_dev = '0; tmo_clr_from_pnl = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
